// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Latency: BIN_W cycles from accepting edge to done; one conversion per BIN_W+2 cycles.
// Backpressure: none; start is honoured only in IDLE, ignored (not queued) while busy.
module bin2bcd_seq #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5,
   parameter int SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  sign_out,
   output logic                  overflow
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state, state_nxt;
   logic               load, shift_en, finish;
   logic [BIN_W-1:0]   bin_reg;
   logic [BCD_W-1:0]   acc, acc_adj, acc_nxt;
   logic               ovf_acc, ovf_nxt;
   logic               sign_reg;
   logic [CNT_W-1:0]   cnt;
   logic               neg;
   logic [BIN_W-1:0]   mag;

   // Two's-complement magnitude; the most negative value maps to 2^(BIN_W-1) exactly
   assign neg = (SIGNED != 0) && bin_in[BIN_W-1];
   assign mag = neg ? (~bin_in + BIN_W'(1)) : bin_in;

   always_comb begin
      acc_adj = acc;
      for (int d = 0; d < DIGITS; d++) begin
         if (acc[4*d +: 4] >= 4'd5)
            acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
   end

   assign acc_nxt = {acc_adj[BCD_W-2:0], bin_reg[BIN_W-1]};
   assign ovf_nxt = ovf_acc | acc_adj[BCD_W-1];
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift_en  = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (cnt == CNT_W'(1)) begin
               finish    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bin_reg  <= '0;
         acc      <= '0;
         ovf_acc  <= 1'b0;
         sign_reg <= 1'b0;
         cnt      <= '0;
         done     <= 1'b0;
         bcd_out  <= '0;
         sign_out <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            bin_reg  <= mag;
            acc      <= '0;
            ovf_acc  <= 1'b0;
            sign_reg <= neg;
            cnt      <= CNT_W'(BIN_W);
         end else if (shift_en) begin
            bin_reg <= {bin_reg[BIN_W-2:0], 1'b0};
            acc     <= acc_nxt;
            ovf_acc <= ovf_nxt;
            cnt     <= cnt - CNT_W'(1);
         end
         // Results are published only on the completing edge and held otherwise
         if (finish) begin
            bcd_out  <= acc_nxt;
            overflow <= ovf_nxt;
            sign_out <= sign_reg;
         end
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: three instances (5-digit unsigned, 4-digit unsigned, 5-digit signed).
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  start_v = '0;
   logic [15:0] bin_v [3];
   logic [2:0]  busy_v, done_v, sign_v, ovf_v;
   logic [19:0] bcd_a, bcd_c;
   logic [15:0] bcd_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .bin_in(bin_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .bcd_out(bcd_a),
      .sign_out(sign_v[0]), .overflow(ovf_v[0]));

   bin2bcd_seq #(.BIN_W(16), .DIGITS(4), .SIGNED(0)) u_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .bin_in(bin_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .bcd_out(bcd_b),
      .sign_out(sign_v[1]), .overflow(ovf_v[1]));

   bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1)) u_c (
      .clk(clk), .rst(rst), .start(start_v[2]), .bin_in(bin_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .bcd_out(bcd_c),
      .sign_out(sign_v[2]), .overflow(ovf_v[2]));

   function automatic logic [19:0] get_bcd(input int w);
      case (w)
         0:       return bcd_a;
         1:       return {4'h0, bcd_b};
         default: return bcd_c;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run(input int w, input logic [15:0] val, input logic [19:0] exp_bcd,
                      input logic exp_ovf, input logic exp_sign, input string tag);
      int cyc, bcnt;
      bit seen;
      @(negedge clk);
      start_v[w] = 1'b1;
      bin_v[w]   = val;
      @(negedge clk);
      start_v[w] = 1'b0;
      bin_v[w]   = 16'hA5A5;
      cyc  = 0;
      bcnt = int'(busy_v[w]);
      seen = 0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (busy_v[w]) bcnt++;
         if (done_v[w]) seen = 1;
      end
      check({tag, " latency"}, cyc, 16);
      check({tag, " bcd"}, get_bcd(w), exp_bcd);
      check({tag, " ovf"}, ovf_v[w], exp_ovf);
      check({tag, " sign"}, sign_v[w], exp_sign);
      @(negedge clk);
      check({tag, " done fall"}, done_v[w], 1'b0);
      check({tag, " busy fall"}, busy_v[w], 1'b0);
      check({tag, " busy cycles"}, bcnt, 17);
   endtask

   initial begin
      int cyc, d1, d2, dcnt;
      for (int i = 0; i < 3; i++) bin_v[i] = '0;

      repeat (2) @(negedge clk);
      check("reset busy", busy_v, 3'b000);
      check("reset done", done_v, 3'b000);
      check("reset bcd_a", bcd_a, 20'h0);
      check("reset sign/ovf", {sign_v, ovf_v}, 6'b0);
      rst = 1'b1;
      @(negedge clk);

      run(0, 16'hFFFF, 20'h65535, 1'b0, 1'b0, "a_ffff");

      // Back-to-back with start held high
      @(negedge clk);
      start_v[0] = 1'b1;
      bin_v[0]   = 16'h0000;
      @(negedge clk);
      bin_v[0] = 16'h0009;
      cyc = 0; d1 = -1; d2 = -1;
      while (d2 < 0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (done_v[0]) begin
            if (d1 < 0) begin
               d1 = cyc;
               check("b2b first bcd", bcd_a, 20'h00000);
            end else begin
               d2 = cyc;
               start_v[0] = 1'b0;
               check("b2b second bcd", bcd_a, 20'h00009);
            end
         end
      end
      start_v[0] = 1'b0;
      check("b2b first latency", d1, 16);
      check("b2b spacing", d2 - d1, 18);
      repeat (3) @(negedge clk);
      check("b2b idle", busy_v[0], 1'b0);

      run(1, 16'd9999, 20'h09999, 1'b0, 1'b0, "b_9999");
      run(1, 16'd10000, 20'h00000, 1'b1, 1'b0, "b_10000");
      run(1, 16'hFFFF, 20'h05535, 1'b1, 1'b0, "b_ffff");

      run(2, 16'h8000, 20'h32768, 1'b0, 1'b1, "c_8000");
      run(2, 16'hFFFF, 20'h00001, 1'b0, 1'b1, "c_ffff");
      run(2, 16'h7FFF, 20'h32767, 1'b0, 1'b0, "c_7fff");

      // start pulses while busy must be ignored
      @(negedge clk);
      start_v[0] = 1'b1;
      bin_v[0]   = 16'h1111;
      @(negedge clk);
      start_v[0] = 1'b0;
      cyc = 0; dcnt = 0;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (done_v[0]) begin
            dcnt++;
            check("ignore bcd", bcd_a, 20'h04369);
         end
         if (cyc == 10) check("ignore hold", bcd_a, 20'h00009);
         if (cyc == 5 || cyc == 16) begin
            start_v[0] = 1'b1;
            bin_v[0]   = 16'h2222;
         end else begin
            start_v[0] = 1'b0;
         end
      end
      check("ignore done count", dcnt, 1);
      check("ignore idle", busy_v[0], 1'b0);

      // Reset mid-conversion
      @(negedge clk);
      start_v[0] = 1'b1;
      bin_v[0]   = 16'h1234;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort busy", busy_v[0], 1'b0);
      check("abort done", done_v[0], 1'b0);
      check("abort bcd", bcd_a, 20'h0);
      repeat (2) @(negedge clk);
      rst  = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done_v[0]) dcnt++;
      end
      check("abort no done", dcnt, 0);
      run(0, 16'h1234, 20'h04660, 1'b0, 1'b0, "a_after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It generalises our combinational per-digit add-3 separator stage:
- input width, digit count and signedness are parameters;
- a start/done handshake is added;
- out-of-range results are flagged.

It sits between the arithmetic datapath and the display/decoder logic. A single instance serves any operand width.

## Interface
- BIN_W, 16, binary operand width (≥2)
- DIGITS, 5, BCD output digit count (≥1); 4 bits per digit
- SIGNED, 0, 1: bin_in is two's complement; magnitude is converted and sign reported
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request conversion of bin_in; sampled only in IDLE
- bin_in  input  BIN_W  operand, captured on the accepting edge
- busy  output  1  high in SHIFT and DONE states
- done  output  1  one-cycle pulse; bcd_out/sign_out/overflow valid from this cycle
- bcd_out  output  4*DIGITS  result, digit 0 in bits [3:0]; held until next completion
- sign_out  output  1  1 = negative operand (SIGNED=1 only; tied 0 otherwise)
- overflow  output  1  1 = value ≥ 10^DIGITS; bcd_out = value mod 10^DIGITS

## Operation
- Reset (rst=0, asynchronous): state=IDLE, all registers and outputs 0.
- **IDLE**:
  - start=1 loads the operand into the working binary register, clears the BCD accumulator and the overflow accumulator, loads counter=BIN_W, and moves to SHIFT.
  - The value loaded is bin_in. When SIGNED=1 and bin_in[MSB]=1, it is the two's-complement magnitude instead.
  - −2^(BIN_W−1) yields magnitude 2^(BIN_W−1), which is represented exactly.
  - The sign is latched at the same edge.
- **SHIFT** (one iteration per edge):
  - Every accumulator digit ≥5 has 3 added, modulo 16 within the digit.
  - Then {accumulator, binary register} shifts left by 1.
  - The bit leaving the top digit is ORed into the overflow accumulator.
  - counter decrements.
  - On the edge where counter==1, the fully updated accumulator is written to bcd_out, the sign to sign_out and the overflow accumulator to overflow. done<=1 and state<=DONE.
- **DONE**: lasts one cycle. The next edge gives done<=0 and state<=IDLE.
- start in SHIFT or DONE is ignored and not queued.
- Digit adjustment is per digit, in parallel, and uses 4-bit arithmetic only. No carry crosses digit boundaries except via the shift.
- Truncation: upper digits are discarded. Lower digits remain exact because adjustment only propagates upward.

## Timing
- Accepting edge = E0 (IDLE, start=1). busy is high from E0 onward.
- done=1 and the new outputs are visible after edge E0+BIN_W. Latency is BIN_W cycles from accept to done.
- done and busy fall after E0+BIN_W+1.
- The earliest next accept is at edge E0+BIN_W+2. Throughput is one conversion per BIN_W+2 cycles with start held high.
- bin_in needs to be stable only at E0.
- Reset mid-conversion aborts immediately: outputs return to 0 and no done is produced. After release, the first accept follows the same timing.
- bcd_out, sign_out and overflow change only on a done edge or on reset. They are stable in all other cycles.

## Test plan
- BIN_W=16, DIGITS=5, SIGNED=0:
  - Stimulus: start with bin_in=0xFFFF.
  - Response: done exactly 16 cycles after accept, bcd_out=0x65535, overflow=0, busy high for 17 cycles.
- Same configuration, bin_in=0x0000 then 0x0009 back-to-back with start held high:
  - Accepts occur 18 cycles apart.
  - Results are bcd_out=0x00000 and 0x00009.
- DIGITS=4, SIGNED=0:
  - bin_in=9999 gives bcd_out=0x9999, overflow=0.
  - bin_in=10000 gives bcd_out=0x0000, overflow=1.
  - bin_in=0xFFFF gives bcd_out=0x5535, overflow=1.
- SIGNED=1, BIN_W=16, DIGITS=5:
  - 0x8000 gives sign_out=1, bcd_out=0x32768.
  - 0xFFFF gives sign_out=1, bcd_out=0x00001.
  - 0x7FFF gives sign_out=0, bcd_out=0x32767.
- Start ignored while busy:
  - Pulse start with a different bin_in at cycles 5 and 16 after accept.
  - Exactly one done pulse results, carrying the first operand's result.
- Reset mid-operation:
  - Assert rst low 8 cycles into a conversion of 0x1234.
  - All outputs go to 0 immediately with no done pulse.
  - After release, a new start with 0x1234 yields 0x04660 after 16 cycles.
